osd_event_packetization_mc: RTL
===============================

// Module: osd_event_packetization_mc
//
// PURPOSE
// Multi-channel successor of the single-source event packetizer. Accepts
// events from NUM_CHANNELS independent sources and grants them round-robin.
// Each event is packed into one or more DI EVENT packets on a single
// debug_out port. The source channel index is carried in FLAGS[9:0].
// Sits between trace/event generators of one debug module and its DI router port.
//
// PARAMETERS
// NUM_CHANNELS        4   number of event sources (1..1024)
// MAX_PKT_LEN         12  max DI packet length in flits incl. 3 header flits (>=4)
// MAX_DATA_NUM_WORDS  8   max payload words per event (>=2)
// Derived (localparams):
//   CH_W  = max(1,$clog2(NUM_CHANNELS))
//   IDX_W = $clog2(MAX_DATA_NUM_WORDS)
//   NW_W  = $clog2(MAX_DATA_NUM_WORDS+1)
//   MAX_PAYLOAD_LEN = MAX_PKT_LEN-3
//
// PORTS
// clk              in   1               clock
// rst              in   1               synchronous, active-high reset
// debug_out        out  dii_flit        DI flit {valid,data[15:0],last}
// debug_out_ready  in   1               DI sink accepts flit
// id               in   16              own DI address (SRC)
// dest             in   16              event destination DI address (DEST)
// event_available  in   NUM_CHANNELS    per-channel event pending
// overflow         in   NUM_CHANNELS    per-channel: send overflow packet instead
// event_consumed   out  NUM_CHANNELS    one-hot 1-cycle pulse: event fully sent
// data_num_words   in   NUM_CHANNELS*NW_W   per-channel payload word count
// data             in   NUM_CHANNELS*16 per-channel data word for data_req_idx
// data_req_ch      out  CH_W            channel currently being read
// data_req_idx     out  IDX_W           word index requested
// data_req_valid   out  1               request valid (PAYLOAD or OVERFLOW state)
//
// BEHAVIOUR
// - Reset: state=ARB, grant=0, last_grant=NUM_CHANNELS-1, counters 0.
//   All outputs 0 (debug_out.valid/last=0, event_consumed=0, data_req_valid=0).
// - FSM states: ARB, DEST, SOURCE, FLAGS, OVERFLOW, PAYLOAD.
//   - ARB: if any event_available, register grant = first requesting channel
//     after last_grant (wrapping); last_grant<=grant; go DEST. No flit is
//     output. Latency: available in ARB -> DEST flit valid the next cycle.
//   - DEST: flit = dest. On ready -> SOURCE.
//   - SOURCE: flit = id. On ready -> FLAGS.
//   - FLAGS: [15:14]=2'b10.
//       [13:10]: 5 if overflow[grant]; else 0 if last pkt of event; else 1.
//       [9:0] = grant zero-extended.
//     On ready:
//       - overflow -> OVERFLOW.
//       - zero-word event -> last=1 on this flit, pulse consumed, go ARB.
//       - otherwise -> PAYLOAD.
//   - OVERFLOW: flit = data[grant], last=1. On ready: pulse consumed, -> ARB.
//   - PAYLOAD: flit = data[grant]; word_cnt++, pflit_cnt++ per accepted flit.
//       - Final word of event: last=1; on ready pulse consumed, clear
//         counters, -> ARB.
//       - pflit_cnt==MAX_PAYLOAD_LEN-1: last=1; on ready pkg_cnt++,
//         pflit_cnt=0, -> DEST, grant kept (packets of one event contiguous,
//         no re-arbitration).
// - Handshake: once valid=1, data/last/data_req_* stay stable until ready.
//   valid never drops without acceptance.
// - grant, overflow[grant] and data_num_words[grant] are sampled at ARB exit
//   into registers and held for the event.
// - event_available[grant] dropping mid-event is ignored; the event completes.
// - Counter math is done in NW_W+1 bits, so data_num_words-1 never wraps.
//   num_pkgs = ceil(nw/MAX_PAYLOAD_LEN).
// - rst mid-packet: abort immediately, no consumed pulse; the sink sees a
//   truncated packet.
// - Simultaneous consumed pulse and new available on same channel: that
//   channel loses priority to the others in the next ARB.
//
// STRUCTURE
// - osd_event_pkg:
//   - TYPE_EVENT=2'b10.
//   - TYPE_SUB_LAST=4'h0, TYPE_SUB_CONTINUE=4'h1, TYPE_SUB_OVERFLOW=4'h5.
//   - NUM_HEADER_FLITS=3.
//   - state enum typedef.
// - Sub-module osd_event_rr_arb #(N): req[N], en, last_grant -> grant, gnt_valid
//   (combinational pick, registered by parent).
//
// TESTING
// 1. ch0, 5 words -> 0x????(dest), id, 0x8000, 5 payload flits, last on 5th;
//    consumed[0] one pulse.
// 2. MAX_DATA_NUM_WORDS=32, ch2, 20 words -> 3 packets of 9/9/2 payload;
//    FLAGS 0x8402, 0x8402, 0x8002.
// 3. ch1 overflow=1, data=0x0007 -> FLAGS 0x9401, payload 0x0007 last=1;
//    data_req_idx=0.
// 4. ch0 and ch2 held available, 4 events each -> grants strictly alternate
//    0,2,0,2...; ch1/ch3 never granted.
// 5. ready low 3 cycles in PAYLOAD idx 2 -> flit, last, data_req_idx=2
//    stable; zero-word event -> 3 flits, last on FLAGS.
// 6. rst asserted mid-PAYLOAD -> next cycle valid=0, state ARB;
//    no consumed pulse; next event starts at DEST.

Source files
------------

// File: rtl/osd_event_pkg.sv
// Shared definitions for the multi-channel OSD event packetizer.
// Holds the DI EVENT packet type codes, the packet header size, the DI flit
// layout carried on the debug port, the packetizer FSM state type and a
// small width helper used by the parameterised modules.
package osd_event_pkg;

    localparam logic [1:0] TYPE_EVENT        = 2'b10;
    localparam logic [3:0] TYPE_SUB_LAST     = 4'h0;
    localparam logic [3:0] TYPE_SUB_CONTINUE = 4'h1;
    localparam logic [3:0] TYPE_SUB_OVERFLOW = 4'h5;
    localparam int         NUM_HEADER_FLITS  = 3;

    // One DI flit as seen by the router port.
    typedef struct packed {
        logic        valid;
        logic [15:0] data;
        logic        last;
    } dii_flit_t;

    typedef enum logic [2:0] {
        ST_ARB,
        ST_DEST,
        ST_SOURCE,
        ST_FLAGS,
        ST_OVERFLOW,
        ST_PAYLOAD
    } state_e;

    // $clog2 that never returns 0, so a single-entry index still has one bit.
    function automatic int min1_clog2(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/osd_event_packetization_mc_if.sv
// DI debug port between the packetizer and its router port.
//   flit  : {valid, data[15:0], last} driven by the packet source
//   ready : the sink accepts the current flit on this cycle
// master = packet source (packetizer), slave = packet sink (router / bench).
interface osd_event_packetization_mc_if;
    import osd_event_pkg::*;

    dii_flit_t flit;
    logic      ready;

    modport master (output flit, input ready);
    modport slave  (input flit, output ready);

endinterface

// File: rtl/osd_event_rr_arb.sv
// Combinational round-robin pick over N request lines.
//   req        : request per channel
//   en         : pick enable (the parent only arbitrates while idle)
//   last_grant : channel served last; search starts just after it, wrapping
//   grant      : chosen channel (0 when nothing is chosen)
//   gnt_valid  : a channel was chosen
// The parent registers grant, so this block holds no state.
module osd_event_rr_arb
    import osd_event_pkg::*;
#(
    parameter int N = 4,
    localparam int W = min1_clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic         en,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] grant,
    output logic         gnt_valid
);

    logic [W-1:0] cand;

    // NOTE: every signal driven here gets a default before the loop so the
    // block stays purely combinational and cannot infer a latch.
    always_comb begin
        grant     = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        // Offsets 1..N visit every channel once, ending on last_grant itself,
        // so the channel served last has the lowest priority.
        for (int i = 1; i <= N; i++) begin
            cand = W'((int'(last_grant) + i) % N);
            if (en && !gnt_valid && req[cand]) begin
                grant     = cand;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/osd_event_packetization_mc.sv
// Multi-channel DI event packetizer.
// Grants pending events from NUM_CHANNELS sources round-robin and emits each
// as one or more DI EVENT packets (DEST, SOURCE, FLAGS, payload) on debug_out.
// FLAGS[9:0] carries the source channel. Events longer than one packet are
// split into back-to-back packets of the same channel without re-arbitrating.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   debug_out        DI flit port (master side of the debug interface)
//   id, dest         own DI address (SOURCE flit), event destination (DEST flit)
//   event_available  per-channel event pending
//   overflow         per-channel: send a one-word overflow packet instead
//   event_consumed   one-hot pulse on the cycle the event's final flit is taken
//   data_num_words   per-channel payload word count, NW_W bits each
//   data             per-channel payload word answering data_req_idx, 16 bits each
//   data_req_ch/idx  channel and word index currently being read
//   data_req_valid   a payload or overflow word is being read
module osd_event_packetization_mc
    import osd_event_pkg::*;
#(
    parameter int NUM_CHANNELS       = 4,
    parameter int MAX_PKT_LEN        = 12,
    parameter int MAX_DATA_NUM_WORDS = 8,
    localparam int CH_W  = min1_clog2(NUM_CHANNELS),
    localparam int IDX_W = $clog2(MAX_DATA_NUM_WORDS),
    localparam int NW_W  = $clog2(MAX_DATA_NUM_WORDS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    osd_event_packetization_mc_if.master  debug_out,
    input  logic [15:0]                   id,
    input  logic [15:0]                   dest,
    input  logic [NUM_CHANNELS-1:0]       event_available,
    input  logic [NUM_CHANNELS-1:0]       overflow,
    output logic [NUM_CHANNELS-1:0]       event_consumed,
    input  logic [NUM_CHANNELS*NW_W-1:0]  data_num_words,
    input  logic [NUM_CHANNELS*16-1:0]    data,
    output logic [CH_W-1:0]               data_req_ch,
    output logic [IDX_W-1:0]              data_req_idx,
    output logic                          data_req_valid
);

    localparam int MAX_PAYLOAD_LEN = MAX_PKT_LEN - NUM_HEADER_FLITS;
    // One extra bit so nw-1 and nw-word_cnt never wrap.
    localparam int CNT_W = NW_W + 1;
    localparam int PF_W  = min1_clog2(MAX_PAYLOAD_LEN);

    state_e            state;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   arb_grant;
    logic              arb_valid;
    logic              ovf_r;
    logic [NW_W-1:0]   nw_r;
    logic [CNT_W-1:0]  word_cnt;
    logic [PF_W-1:0]   pflit_cnt;

    logic [CNT_W-1:0]  nw_ext;
    logic [CNT_W-1:0]  remaining;
    logic              last_pkt;
    logic              final_word;
    logic              pkt_full;
    logic [3:0]        flags_sub;
    logic [15:0]       data_word;
    logic              event_done;
    dii_flit_t         flit_d;

    osd_event_rr_arb #(.N(NUM_CHANNELS)) u_arb (
        .req        (event_available),
        .en         (state == ST_ARB),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .gnt_valid  (arb_valid)
    );

    assign nw_ext     = {1'b0, nw_r};
    assign remaining  = nw_ext - word_cnt;
    // The packet being started carries the rest of the event if it fits.
    assign last_pkt   = int'(remaining) <= MAX_PAYLOAD_LEN;
    assign final_word = (word_cnt == nw_ext - CNT_W'(1));
    assign pkt_full   = (int'(pflit_cnt) == MAX_PAYLOAD_LEN - 1);
    assign flags_sub  = ovf_r    ? TYPE_SUB_OVERFLOW :
                        last_pkt ? TYPE_SUB_LAST     : TYPE_SUB_CONTINUE;
    assign data_word  = data[int'(grant)*16 +: 16];

    // NOTE: state registers use non-blocking assignments only, so every
    // branch reads the values from before this clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ARB;
            grant      <= '0;
            last_grant <= CH_W'(NUM_CHANNELS - 1);
            ovf_r      <= 1'b0;
            nw_r       <= '0;
            word_cnt   <= '0;
            pflit_cnt  <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (arb_valid) begin
                        grant      <= arb_grant;
                        last_grant <= arb_grant;
                        ovf_r      <= overflow[arb_grant];
                        nw_r       <= data_num_words[int'(arb_grant)*NW_W +: NW_W];
                        word_cnt   <= '0;
                        pflit_cnt  <= '0;
                        state      <= ST_DEST;
                    end
                end
                ST_DEST: begin
                    if (debug_out.ready) state <= ST_SOURCE;
                end
                ST_SOURCE: begin
                    if (debug_out.ready) state <= ST_FLAGS;
                end
                ST_FLAGS: begin
                    if (debug_out.ready) begin
                        if (ovf_r)             state <= ST_OVERFLOW;
                        else if (nw_r == '0)   state <= ST_ARB;
                        else                   state <= ST_PAYLOAD;
                    end
                end
                ST_OVERFLOW: begin
                    if (debug_out.ready) state <= ST_ARB;
                end
                ST_PAYLOAD: begin
                    if (debug_out.ready) begin
                        if (final_word) begin
                            word_cnt  <= '0;
                            pflit_cnt <= '0;
                            state     <= ST_ARB;
                        end else if (pkt_full) begin
                            // Next packet of the same event; grant is kept.
                            word_cnt  <= word_cnt + CNT_W'(1);
                            pflit_cnt <= '0;
                            state     <= ST_DEST;
                        end else begin
                            word_cnt  <= word_cnt + CNT_W'(1);
                            pflit_cnt <= pflit_cnt + PF_W'(1);
                        end
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

    // Flit fields decode the registered state and counters only (plus the
    // source's data word), so they hold steady while the sink stalls.
    always_comb begin
        flit_d         = '0;
        data_req_valid = 1'b0;
        data_req_idx   = '0;
        event_done     = 1'b0;
        case (state)
            ST_DEST: begin
                flit_d.valid = 1'b1;
                flit_d.data  = dest;
            end
            ST_SOURCE: begin
                flit_d.valid = 1'b1;
                flit_d.data  = id;
            end
            ST_FLAGS: begin
                flit_d.valid = 1'b1;
                flit_d.data  = {TYPE_EVENT, flags_sub, 10'(grant)};
                flit_d.last  = !ovf_r && (nw_r == '0);
                event_done   = flit_d.last;
            end
            ST_OVERFLOW: begin
                flit_d.valid   = 1'b1;
                flit_d.data    = data_word;
                flit_d.last    = 1'b1;
                data_req_valid = 1'b1;
                event_done     = 1'b1;
            end
            ST_PAYLOAD: begin
                flit_d.valid   = 1'b1;
                flit_d.data    = data_word;
                flit_d.last    = final_word || pkt_full;
                data_req_valid = 1'b1;
                data_req_idx   = word_cnt[IDX_W-1:0];
                event_done     = final_word;
            end
            default: ;
        endcase
    end

    // The consumed pulse is combinational with the accepting handshake so the
    // source can withdraw event_available on that same edge; the following
    // ARB cycle then never sees the finished event again.
    always_comb begin
        event_consumed = '0;
        if (event_done && debug_out.ready) event_consumed[grant] = 1'b1;
    end

    assign debug_out.flit = flit_d;
    assign data_req_ch    = grant;

endmodule
